udma_hyper_rx_packer: RTL and testbench

UDMA_HYPER_RX_PACKER -- requirements
Module: udma_hyper_rx_packer

---
 rtl/udma_hyper_rx_packer.sv | 182 ++++++++++++++++++
 tb/tb_udma_hyper_rx_packer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_hyper_rx_packer.sv
// HyperBus RX packer: collects 16-bit PHY beats into 8/16/32-bit elements
// and hands them to the uDMA RX channel through a small dual-write FIFO.
module udma_hyper_rx_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  input  logic        cfg_start_i,
  input  logic [15:0] cfg_len_i,
  input  logic [1:0]  cfg_datasize_i,
  input  logic        cfg_clr_i,
  input  logic [15:0] phy_data_i,
  input  logic        phy_valid_i,
  output logic [31:0] data_rx_o,
  output logic        data_rx_valid_o,
  input  logic        data_rx_ready_i,
  output logic [1:0]  data_rx_datasize_o,
  output logic        busy_o,
  output logic        evt_done_o,
  output logic        evt_ovf_o,
  output logic        ovf_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } state_t;

  state_t      state;
  logic [15:0] rem_cnt;
  logic [1:0]  dsize;
  logic [31:0] part;
  logic [1:0]  part_cnt;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        beat;
  logic        pop;
  logic [1:0]  n_acc;
  logic [2:0]  ew;
  logic [31:0] e;
  logic [2:0]  ec;
  logic [7:0]  bt;
  logic [1:0]  np;
  logic [31:0] pd0;
  logic [31:0] pd1;
  logic [AW:0] free;
  logic        ovf_beat;
  logic [1:0]  push_n;
  logic [15:0] rem_n;

  assign beat            = (state == ACTIVE) && phy_valid_i;
  assign data_rx_valid_o = (count != '0);
  assign pop             = data_rx_valid_o && data_rx_ready_i;
  assign data_rx_o       = mem[rd_ptr];
  assign data_rx_datasize_o = dsize;

  assign n_acc = (rem_cnt >= 16'd2) ? 2'd2 : rem_cnt[1:0];
  assign rem_n = rem_cnt - {14'd0, n_acc};

  always_comb begin
    case (dsize)
      2'b00:   ew = 3'd1;
      2'b01:   ew = 3'd2;
      default: ew = 3'd4;
    endcase
  end

  // Walk the (up to) two accepted bytes, closing an element when it is
  // full or when the transfer's last byte lands in it.
  always_comb begin
    e   = part;
    ec  = {1'b0, part_cnt};
    np  = 2'd0;
    pd0 = '0;
    pd1 = '0;
    bt  = '0;
    for (int k = 0; k < 2; k++) begin
      if (beat && (2'(k) < n_acc)) begin
        bt = (k == 0) ? phy_data_i[7:0] : phy_data_i[15:8];
        e[{ec[1:0], 3'b000} +: 8] = bt;
        ec = ec + 3'd1;
        if ((ec == ew) || (rem_cnt == 16'(k + 1))) begin
          if (np == 2'd0) pd0 = e;
          else pd1 = e;
          np = np + 2'd1;
          e  = '0;
          ec = '0;
        end
      end
    end
  end

  // A pop this cycle frees its slot for a push in the same cycle.
  assign free     = (AW+1)'(FIFO_DEPTH) - count + (AW+1)'(pop);
  assign ovf_beat = beat && ((AW+1)'(np) > free);
  assign push_n   = (beat && !ovf_beat) ? np : 2'd0;

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      rem_cnt    <= '0;
      dsize      <= '0;
      part       <= '0;
      part_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      busy_o     <= 1'b0;
      evt_done_o <= 1'b0;
      evt_ovf_o  <= 1'b0;
      ovf_o      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      evt_done_o <= 1'b0;
      evt_ovf_o  <= 1'b0;
      if (cfg_clr_i) begin
        state    <= IDLE;
        busy_o   <= 1'b0;
        rem_cnt  <= '0;
        part     <= '0;
        part_cnt <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push_n != 2'd0) mem[wr_ptr] <= pd0;
        if (push_n == 2'd2) mem[wr_ptr + AW'(1)] <= pd1;
        wr_ptr <= wr_ptr + AW'(push_n);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push_n) - (AW+1)'(pop);
        unique case (state)
          IDLE: begin
            if (cfg_start_i) begin
              if (cfg_len_i != 16'd0) begin
                state    <= ACTIVE;
                busy_o   <= 1'b1;
                rem_cnt  <= cfg_len_i;
                dsize    <= (cfg_datasize_i == 2'b11) ? 2'b10 : cfg_datasize_i;
                ovf_o    <= 1'b0;
                part     <= '0;
                part_cnt <= '0;
              end else begin
                evt_done_o <= 1'b1;
              end
            end
          end
          ACTIVE: begin
            if (beat) begin
              rem_cnt  <= rem_n;
              part     <= e;
              part_cnt <= ec[1:0];
              if (ovf_beat) begin
                ovf_o     <= 1'b1;
                evt_ovf_o <= 1'b1;
              end
              if (rem_n == 16'd0) state <= FLUSH;
            end
          end
          FLUSH: begin
            if (count == '0) begin
              state      <= IDLE;
              busy_o     <= 1'b0;
              evt_done_o <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udma_hyper_rx_packer.sv
// Scoreboard bench for udma_hyper_rx_packer: directed transfers,
// expected elements queued at stimulus time, checked by a negedge monitor.
module tb_udma_hyper_rx_packer;

  logic        sys_clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_start_i = 1'b0;
  logic [15:0] cfg_len_i = '0;
  logic [1:0]  cfg_datasize_i = '0;
  logic        cfg_clr_i = 1'b0;
  logic [15:0] phy_data_i = '0;
  logic        phy_valid_i = 1'b0;
  logic [31:0] data_rx_o;
  logic        data_rx_valid_o;
  logic        data_rx_ready_i = 1'b1;
  logic [1:0]  data_rx_datasize_o;
  logic        busy_o;
  logic        evt_done_o;
  logic        evt_ovf_o;
  logic        ovf_o;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int ovf_cnt = 0;
  int base_done;
  int base_ovf;
  logic [33:0] exp_q[$];

  udma_hyper_rx_packer #(.FIFO_DEPTH(4)) dut (
    .sys_clk_i          (sys_clk_i),
    .rst_i              (rst_i),
    .cfg_start_i        (cfg_start_i),
    .cfg_len_i          (cfg_len_i),
    .cfg_datasize_i     (cfg_datasize_i),
    .cfg_clr_i          (cfg_clr_i),
    .phy_data_i         (phy_data_i),
    .phy_valid_i        (phy_valid_i),
    .data_rx_o          (data_rx_o),
    .data_rx_valid_o    (data_rx_valid_o),
    .data_rx_ready_i    (data_rx_ready_i),
    .data_rx_datasize_o (data_rx_datasize_o),
    .busy_o             (busy_o),
    .evt_done_o         (evt_done_o),
    .evt_ovf_o          (evt_ovf_o),
    .ovf_o              (ovf_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon();
    logic [33:0] x;
    if (evt_done_o) done_cnt++;
    if (evt_ovf_o) ovf_cnt++;
    if (data_rx_valid_o && data_rx_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got %h expected none", data_rx_o);
      end else begin
        x = exp_q.pop_front();
        check("rx_data", data_rx_o, x[31:0]);
        check("rx_dsize", {30'd0, data_rx_datasize_o}, {30'd0, x[33:32]});
      end
    end
  endtask

  always @(negedge sys_clk_i) mon();

  task automatic step();
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic start(input logic [15:0] len, input logic [1:0] ds);
    cfg_start_i    = 1'b1;
    cfg_len_i      = len;
    cfg_datasize_i = ds;
    step();
    cfg_start_i = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d);
    phy_valid_i = 1'b1;
    phy_data_i  = d;
    step();
    phy_valid_i = 1'b0;
  endtask

  task automatic expect_el(input logic [1:0] ds, input logic [31:0] d);
    exp_q.push_back({ds, d});
  endtask

  task automatic wait_done(input string nm, input int base);
    for (int i = 0; i < 50; i++) begin
      if (done_cnt > base) break;
      step();
    end
    repeat (2) step();
    check(nm, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic check_zero_outs(input string nm);
    check({nm, "_data"}, data_rx_o, 32'd0);
    check({nm, "_flags"},
          {26'd0, data_rx_valid_o, busy_o, evt_done_o, evt_ovf_o, ovf_o,
           |data_rx_datasize_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) step();
    check_zero_outs("reset");
    rst_i = 1'b0;
    step();

    // zero-length start
    base_done = done_cnt;
    start(16'd0, 2'b10);
    check("zlen_busy", {31'd0, busy_o}, 32'd0);
    repeat (2) step();
    check("zlen_done", 32'(done_cnt - base_done), 32'd1);

    // word mode, length 8
    base_done = done_cnt;
    start(16'd8, 2'b10);
    check("w8_busy", {31'd0, busy_o}, 32'd1);
    expect_el(2'b10, 32'h44332211);
    expect_el(2'b10, 32'h88776655);
    beat(16'h2211);
    check("w8_notyet", {31'd0, data_rx_valid_o}, 32'd0);
    beat(16'h4433);
    check("w8_latency", {31'd0, data_rx_valid_o}, 32'd1);
    beat(16'h6655);
    beat(16'h8877);
    wait_done("w8_done", base_done);
    check("w8_idle", {31'd0, busy_o}, 32'd0);
    check("w8_drained", 32'(exp_q.size()), 32'd0);

    // byte mode, length 3, odd byte discarded
    base_done = done_cnt;
    start(16'd3, 2'b00);
    expect_el(2'b00, 32'h000000AA);
    expect_el(2'b00, 32'h000000BB);
    expect_el(2'b00, 32'h000000CC);
    beat(16'hBBAA);
    beat(16'hDDCC);
    wait_done("b3_done", base_done);
    check("b3_drained", 32'(exp_q.size()), 32'd0);

    // half mode, length 5, partial last element
    base_done = done_cnt;
    start(16'd5, 2'b01);
    check("h5_dsize", {30'd0, data_rx_datasize_o}, 32'd1);
    expect_el(2'b01, 32'h00000201);
    expect_el(2'b01, 32'h00000403);
    expect_el(2'b01, 32'h00000005);
    beat(16'h0201);
    beat(16'h0403);
    beat(16'h0605);
    wait_done("h5_done", base_done);
    check("h5_drained", 32'(exp_q.size()), 32'd0);

    // datasize 11 is reported as word
    base_done = done_cnt;
    start(16'd2, 2'b11);
    check("ds11_map", {30'd0, data_rx_datasize_o}, 32'd2);
    expect_el(2'b10, 32'h0000BEEF);
    beat(16'hBEEF);
    wait_done("ds11_done", base_done);

    // overflow: byte mode, length 12, no draining
    data_rx_ready_i = 1'b0;
    base_done = done_cnt;
    base_ovf  = ovf_cnt;
    start(16'd12, 2'b00);
    expect_el(2'b00, 32'h01);
    expect_el(2'b00, 32'h02);
    expect_el(2'b00, 32'h03);
    expect_el(2'b00, 32'h04);
    beat(16'h0201);
    beat(16'h0403);
    check("ovf_full_noflag", {31'd0, ovf_o}, 32'd0);
    beat(16'h0605);
    beat(16'h0807);
    beat(16'h0A09);
    beat(16'h0C0B);
    repeat (2) step();
    check("ovf_pulses", 32'(ovf_cnt - base_ovf), 32'd4);
    check("ovf_sticky", {31'd0, ovf_o}, 32'd1);
    check("ovf_nodone", 32'(done_cnt - base_done), 32'd0);
    data_rx_ready_i = 1'b1;
    wait_done("ovf_done", base_done);
    check("ovf_drained", 32'(exp_q.size()), 32'd0);
    check("ovf_kept", {31'd0, ovf_o}, 32'd1);

    // abort with cfg_clr_i after 3 beats
    base_done = done_cnt;
    start(16'd16, 2'b10);
    check("clr_ovf_cleared", {31'd0, ovf_o}, 32'd0);
    expect_el(2'b10, 32'h44332211);
    beat(16'h2211);
    beat(16'h4433);
    beat(16'h6655);
    cfg_clr_i = 1'b1;
    step();
    cfg_clr_i = 1'b0;
    check("clr_busy", {31'd0, busy_o}, 32'd0);
    check("clr_valid", {31'd0, data_rx_valid_o}, 32'd0);
    repeat (4) step();
    check("clr_nodone", 32'(done_cnt - base_done), 32'd0);
    start(16'd4, 2'b10);
    expect_el(2'b10, 32'hDDCCBBAA);
    beat(16'hBBAA);
    beat(16'hDDCC);
    wait_done("clr_restart_done", base_done);
    check("clr_drained", 32'(exp_q.size()), 32'd0);

    // reset mid-transfer with 2 entries held
    data_rx_ready_i = 1'b0;
    base_done = done_cnt;
    base_ovf  = ovf_cnt;
    start(16'd16, 2'b10);
    beat(16'h2211);
    beat(16'h4433);
    beat(16'h6655);
    beat(16'h8877);
    check("rst_held", {31'd0, data_rx_valid_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check_zero_outs("rst_mid");
    step();
    rst_i = 1'b0;
    data_rx_ready_i = 1'b1;
    repeat (5) step();
    check("rst_nodone", 32'(done_cnt - base_done), 32'd0);
    check("rst_noovf", 32'(ovf_cnt - base_ovf), 32'd0);
    check("rst_empty", {31'd0, data_rx_valid_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
